// File: rtl/shift_chain_lfsr.sv
// shift_chain_lfsr: N-stage register chain that holds, shifts, parallel-loads or runs as a
// Fibonacci LFSR with lock-up escape. Optional period measurement: SHIFT_CHAIN_LFSR_PERIOD_CHECK_EN.
module shift_chain_lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] match_val,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             y,
  output logic             match,
  output logic             lockup,
  output logic [CNT_W-1:0] step_cnt,
  output logic             cnt_wrap,
  output logic [CNT_W-1:0] period,
  output logic             period_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lockup_nxt;
  logic             wrap_nxt;

  assign mode_s = mode_e'(mode);

  // Observation outputs are pure functions of the chain so they track q in the same cycle.
  assign sout  = q[WIDTH-1];
  assign y     = ~^q;
  assign match = (q == match_val);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    q_nxt      = q;
    cnt_nxt    = step_cnt;
    lockup_nxt = 1'b0;
    wrap_nxt   = 1'b0;
    if (en) begin
      unique case (mode_s)
        MODE_SHIFT: q_nxt = {q[WIDTH-2:0], din};
        MODE_LOAD: begin
          q_nxt   = load_val;
          cnt_nxt = '0;
        end
        MODE_LFSR: begin
          // An all-zero chain would never leave zero, so inject the seed instead.
          if (q == '0) begin
            q_nxt      = SEED;
            lockup_nxt = 1'b1;
          end else begin
            q_nxt = {q[WIDTH-2:0], ^(q & TAPS)};
          end
          cnt_nxt  = step_cnt + CNT_W'(1);
          wrap_nxt = (step_cnt == '1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      step_cnt <= '0;
      lockup   <= 1'b0;
      cnt_wrap <= 1'b0;
    end else begin
      q        <= q_nxt;
      step_cnt <= cnt_nxt;
      lockup   <= lockup_nxt;
      cnt_wrap <= wrap_nxt;
    end
  end

`ifdef SHIFT_CHAIN_LFSR_PERIOD_CHECK_EN
  logic             lfsr_step;
  logic             seed_inj;
  logic             clear_ref;
  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] ref_nxt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_nxt;
  logic [CNT_W-1:0] pcnt_inc;
  logic [CNT_W-1:0] period_nxt;
  logic             ref_valid;
  logic             rv_nxt;
  logic             pdone_nxt;

  assign lfsr_step = en && (mode_s == MODE_LFSR);
  assign seed_inj  = lfsr_step && (q == '0);
  assign clear_ref = en && ((mode_s == MODE_SHIFT) || (mode_s == MODE_LOAD));
  assign pcnt_inc  = pcnt + CNT_W'(1);

  // The reference is the first state seen after a non-LFSR disturbance (or the seed);
  // the period is the number of steps until the chain returns to it.
  always_comb begin
    ref_nxt    = ref_state;
    pcnt_nxt   = pcnt;
    rv_nxt     = ref_valid;
    period_nxt = period;
    pdone_nxt  = 1'b0;
    if (clear_ref) begin
      rv_nxt = 1'b0;
    end else if (seed_inj) begin
      ref_nxt  = SEED;
      pcnt_nxt = '0;
      rv_nxt   = 1'b1;
    end else if (lfsr_step && !ref_valid) begin
      ref_nxt  = q;
      pcnt_nxt = CNT_W'(1);
      rv_nxt   = 1'b1;
    end else if (lfsr_step) begin
      if (q_nxt == ref_state) begin
        period_nxt = pcnt_inc;
        pdone_nxt  = 1'b1;
        pcnt_nxt   = '0;
      end else begin
        pcnt_nxt = pcnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_state   <= '0;
      pcnt        <= '0;
      ref_valid   <= 1'b0;
      period      <= '0;
      period_done <= 1'b0;
    end else begin
      ref_state   <= ref_nxt;
      pcnt        <= pcnt_nxt;
      ref_valid   <= rv_nxt;
      period      <= period_nxt;
      period_done <= pdone_nxt;
    end
  end
`else
  assign period      = '0;
  assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_shift_chain_lfsr.sv
// Self-checking bench for shift_chain_lfsr (WIDTH=4, TAPS=1100, SEED=0001, CNT_W=4) against
// an arithmetic reference model; honours SHIFT_CHAIN_LFSR_PERIOD_CHECK_EN for the period outputs.
module tb_shift_chain_lfsr;

  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 4;
  localparam logic [3:0]  TAPS = 4'b1100;
  localparam logic [3:0]  SEED = 4'b0001;
`ifdef SHIFT_CHAIN_LFSR_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          din = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  match_val = '0;
  logic [W-1:0]  q;
  logic          sout, y, match, lockup, cnt_wrap, period_done;
  logic [CW-1:0] step_cnt, period;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers).
  int m_q, m_cnt, m_ref, m_pcnt, m_period;
  bit m_lock, m_wrap, m_pdone, m_rv;

  shift_chain_lfsr #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
    .load_val(load_val), .match_val(match_val), .q(q), .sout(sout), .y(y),
    .match(match), .lockup(lockup), .step_cnt(step_cnt), .cnt_wrap(cnt_wrap),
    .period(period), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_ref = 0; m_pcnt = 0; m_period = 0;
    m_lock = 0; m_wrap = 0; m_pdone = 0; m_rv = 0;
  endtask

  // Apply one command, advance the model by the rules, and move to #1 after the edge.
  task automatic tick(input logic e, input logic [1:0] md, input logic d, input logic [3:0] lv);
    int prev;
    bit was_zero;
    en = e; mode = md; din = d; load_val = lv;
    m_lock = 0; m_wrap = 0; m_pdone = 0;
    if (e && md == 2'b01) begin
      m_q  = ((m_q * 2) + int'(d)) % 16;
      m_rv = 0;
    end else if (e && md == 2'b11) begin
      m_q   = int'(lv);
      m_cnt = 0;
      m_rv  = 0;
    end else if (e && md == 2'b10) begin
      prev     = m_q;
      was_zero = (m_q == 0);
      if (was_zero) begin
        m_q    = int'(SEED);
        m_lock = 1;
      end else begin
        m_q = ((m_q * 2) + ($countones(m_q & int'(TAPS)) % 2)) % 16;
      end
      m_wrap = (m_cnt == 15);
      m_cnt  = (m_cnt + 1) % 16;
      if (was_zero) begin
        m_ref = int'(SEED); m_pcnt = 0; m_rv = 1;
      end else if (!m_rv) begin
        m_ref = prev; m_pcnt = 1; m_rv = 1;
      end else begin
        m_pcnt = (m_pcnt + 1) % 16;
        if (m_q == m_ref) begin
          m_period = m_pcnt; m_pdone = 1; m_pcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] expected_vec();
    logic [3:0] eq, ec, ep;
    eq = m_q[3:0];
    ec = m_cnt[3:0];
    ep = PCHK ? m_period[3:0] : 4'd0;
    return {eq, eq[3], ~^eq, (eq == match_val), m_lock, m_wrap, ec, ep, PCHK & m_pdone};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    match_val = 4'd0;
    model_reset();
    #12;
    total++;
    if ({q, sout, y, lockup, cnt_wrap, step_cnt} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state: got q=%b sout=%b y=%b lk=%b wr=%b cnt=%0d, want q=0000 sout=0 y=1 lk=0 wr=0 cnt=0",
               q, sout, y, lockup, cnt_wrap, step_cnt);
    end
    total++;
    if ({period, period_done} !== 5'd0) begin
      bad++;
      $display("FAIL reset_period: got period=%0d done=%b, want 0/0", period, period_done);
    end
    #1;
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL reset_match_zero: got %b want 1", match); end
    match_val = 4'd5;
    #1;
    total++;
    if (match !== 1'b0) begin bad++; $display("FAIL reset_match_nonzero: got %b want 0", match); end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_lockup_escape();
    logic [3:0] exp_q [4];
    logic       exp_y [4];
    logic       exp_l [4];
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    exp_y = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'b10, 1'b0, 4'd0);
      total++;
      if ({q, y, lockup, step_cnt} !== {exp_q[i], exp_y[i], exp_l[i], 4'(i + 1)}) begin
        bad++;
        $display("FAIL lockup_step%0d: got q=%b y=%b lk=%b cnt=%0d, want q=%b y=%b lk=%b cnt=%0d",
                 i, q, y, lockup, step_cnt, exp_q[i], exp_y[i], exp_l[i], i + 1);
      end
    end
  endtask

  task automatic test_load_shift();
    tick(1'b1, 2'b11, 1'b0, 4'b1011);
    total++;
    if ({q, sout, step_cnt} !== {4'b1011, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL load: got q=%b sout=%b cnt=%0d, want 1011 1 0", q, sout, step_cnt);
    end
    tick(1'b1, 2'b01, 1'b1, 4'd0);
    total++;
    if ({q, sout, step_cnt} !== {4'b0111, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL shift_din1: got q=%b sout=%b cnt=%0d, want 0111 0 0", q, sout, step_cnt);
    end
    tick(1'b1, 2'b01, 1'b0, 4'd0);
    total++;
    if ({q, sout, step_cnt} !== {4'b1110, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL shift_din0: got q=%b sout=%b cnt=%0d, want 1110 1 0", q, sout, step_cnt);
    end
  endtask

  task automatic test_hold();
    logic [3:0] cnt0;
    tick(1'b1, 2'b11, 1'b0, 4'b0110);
    match_val = 4'b0110;
    cnt0 = step_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 1) tick(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
      else            tick(1'b1, 2'b00, 1'($urandom), 4'($urandom));
      total++;
      if ({q, step_cnt, lockup, cnt_wrap, period_done, match} !== {4'b0110, cnt0, 4'b0001}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got q=%b cnt=%0d lk=%b wr=%b pd=%b m=%b, want q=0110 cnt=%0d pulses=0 m=1",
                 i, q, step_cnt, lockup, cnt_wrap, period_done, match, cnt0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 3; i++) tick(1'b1, 2'b10, 1'b0, 4'd0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({q, y, step_cnt} !== {4'd0, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL reset_mid_async: got q=%b y=%b cnt=%0d, want 0000 1 0", q, y, step_cnt);
    end
    @(posedge clk); #1;
    total++;
    if ({q, lockup} !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid_held: got q=%b lk=%b, want 0000 0", q, lockup);
    end
    en = 1'b0; mode = 2'b00;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_counter_wrap();
    int wraps = 0;
    tick(1'b1, 2'b11, 1'b0, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 2'b10, 1'b0, 4'd0);
      if (cnt_wrap === 1'b1) wraps++;
      total++;
      if ({step_cnt, cnt_wrap} !== {m_cnt[3:0], m_wrap}) begin
        bad++;
        $display("FAIL wrap_step%0d: got cnt=%0d wr=%b, want cnt=%0d wr=%b", i, step_cnt, cnt_wrap, m_cnt, m_wrap);
      end
    end
    total++;
    if (wraps != 1 || step_cnt !== 4'd0) begin
      bad++;
      $display("FAIL wrap_summary: got pulses=%0d cnt=%0d, want pulses=1 cnt=0", wraps, step_cnt);
    end
  endtask

  task automatic test_period();
    int pulses = 0;
    tick(1'b1, 2'b11, 1'b0, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 2'b10, 1'b0, 4'd0);
      if (period_done === 1'b1) pulses++;
      total++;
      if ({period, period_done} !== {(PCHK ? m_period[3:0] : 4'd0), PCHK & m_pdone}) begin
        bad++;
        $display("FAIL period_step%0d: got period=%0d done=%b, want period=%0d done=%b",
                 i, period, period_done, PCHK ? m_period : 0, PCHK & m_pdone);
      end
    end
    total++;
    if (pulses != (PCHK ? 1 : 0) || period !== (PCHK ? 4'd15 : 4'd0)) begin
      bad++;
      $display("FAIL period_summary: got pulses=%0d period=%0d, want pulses=%0d period=%0d",
               pulses, period, PCHK ? 1 : 0, PCHK ? 15 : 0);
    end
  endtask

  task automatic test_random();
    logic [3:0] lv;
    for (int i = 0; i < 300; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      match_val = ($urandom_range(0, 1) == 0) ? m_q[3:0] : 4'($urandom);
      tick(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 1'($urandom), lv);
      total++;
      if ({q, sout, y, match, lockup, cnt_wrap, step_cnt, period, period_done} !== expected_vec()) begin
        bad++;
        $display("FAIL random_%0d: got %b want %b (q,sout,y,match,lk,wr,cnt,period,pd)",
                 i, {q, sout, y, match, lockup, cnt_wrap, step_cnt, period, period_done}, expected_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockup_escape();
    test_load_shift();
    test_hold();
    test_reset_mid_run();
    test_counter_wrap();
    test_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
